// File: rtl/store_split_unit.sv
// Store alignment stage: turns a right-justified store into lane-aligned memory beats,
// splitting word-crossing stores into two beats or rejecting them when splitting is disabled.
module store_split_unit #(
  parameter int unsigned XLEN             = 32,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [1:0]        req_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  output logic              store_done,
  output logic              store_err
);

  localparam int unsigned NB     = XLEN / 8;
  localparam int unsigned OB     = $clog2(NB);
  localparam bit          HAS_DW = (XLEN == 64);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]     mem_be_q, mem_be_d;
  logic [XLEN-1:0]   b1_addr_q, b1_addr_d;
  logic [XLEN-1:0]   b1_wdata_q, b1_wdata_d;
  logic [NB-1:0]     b1_be_q, b1_be_d;
  logic              split_q, split_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [OB-1:0]     off_c;
  logic [2*NB-1:0]   mask_lo_c, mask_c;
  logic [2:0]        amask_c;
  logic [XLEN-1:0]   keep_c;
  logic [2*XLEN-1:0] data_c;
  logic [XLEN-1:0]   base_c;
  logic              err_c;

  // Request decode: byte mask and data shifted across a double-width window
  always_comb begin
    mask_lo_c = '0;
    amask_c   = '0;
    keep_c    = '0;
    off_c     = req_addr[OB-1:0];
    case (req_size)
      2'd0:    begin mask_lo_c = (2*NB)'(8'h01); amask_c = 3'd0; end
      2'd1:    begin mask_lo_c = (2*NB)'(8'h03); amask_c = 3'd1; end
      2'd2:    begin mask_lo_c = (2*NB)'(8'h0F); amask_c = 3'd3; end
      default: begin mask_lo_c = (2*NB)'(8'hFF); amask_c = 3'd7; end
    endcase
    for (int i = 0; i < NB; i++) begin
      keep_c[8*i +: 8] = {8{mask_lo_c[i]}};
    end
    data_c = (2*XLEN)'(req_wdata & keep_c) << {off_c, 3'b000};
    mask_c = mask_lo_c << off_c;
    base_c = {req_addr[XLEN-1:OB], {OB{1'b0}}};
    err_c  = ((req_size == 2'd3) && !HAS_DW) ||
             (!ALLOW_MISALIGNED && ((off_c & OB'(amask_c)) != '0));
  end

  // Next-state and beat register update
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    b1_addr_d   = b1_addr_q;
    b1_wdata_d  = b1_wdata_q;
    b1_be_d     = b1_be_q;
    split_d     = split_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (err_c) begin
            err_d = 1'b1;
          end else begin
            state_d     = BEAT0;
            mem_addr_d  = base_c;
            mem_be_d    = mask_c[NB-1:0];
            mem_wdata_d = data_c[XLEN-1:0];
            b1_addr_d   = base_c + XLEN'(NB);
            b1_be_d     = mask_c[2*NB-1:NB];
            b1_wdata_d  = data_c[2*XLEN-1:XLEN];
            split_d     = (mask_c[2*NB-1:NB] != '0);
          end
        end
      end
      BEAT0: begin
        if (mem_ready) begin
          if (split_q) begin
            state_d     = BEAT1;
            mem_addr_d  = b1_addr_q;
            mem_be_d    = b1_be_q;
            mem_wdata_d = b1_wdata_q;
          end else begin
            state_d     = IDLE;
            done_d      = 1'b1;
            mem_addr_d  = '0;
            mem_be_d    = '0;
            mem_wdata_d = '0;
          end
        end
      end
      BEAT1: begin
        if (mem_ready) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          mem_addr_d  = '0;
          mem_be_d    = '0;
          mem_wdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      b1_addr_q   <= '0;
      b1_wdata_q  <= '0;
      b1_be_q     <= '0;
      split_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      b1_addr_q   <= b1_addr_d;
      b1_wdata_q  <= b1_wdata_d;
      b1_be_q     <= b1_be_d;
      split_q     <= split_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign mem_valid  = (state_q != IDLE);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;
  assign store_done = done_q;
  assign store_err  = err_q;

endmodule

// File: tb/tb_store_split_unit.sv
// Directed bench for store_split_unit: 32-bit split-enabled, 32-bit strict and 64-bit instances.
module tb_store_split_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared stimulus for the two 32-bit instances
  logic        r_valid;
  logic [31:0] r_addr, r_wdata;
  logic [1:0]  r_size;
  logic        m_ready;

  logic        a_ready, a_valid, a_done, a_err;
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_be;
  logic        s_ready, s_valid, s_done, s_err;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;

  logic        d_valid_i, d_ready_i;
  logic [63:0] d_addr_i, d_wdata_i;
  logic [1:0]  d_size;
  logic        d_ready, d_valid, d_done, d_err;
  logic [63:0] d_addr, d_wdata;
  logic [7:0]  d_be;

  int n_checks = 0;
  int n_fail   = 0;

  store_split_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(r_valid), .req_ready(a_ready),
    .req_addr(r_addr), .req_wdata(r_wdata), .req_size(r_size),
    .mem_valid(a_valid), .mem_ready(m_ready), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .mem_be(a_be), .store_done(a_done), .store_err(a_err));

  store_split_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) u_s (
    .clk(clk), .rst_n(rst_n), .req_valid(r_valid), .req_ready(s_ready),
    .req_addr(r_addr), .req_wdata(r_wdata), .req_size(r_size),
    .mem_valid(s_valid), .mem_ready(m_ready), .mem_addr(s_addr),
    .mem_wdata(s_wdata), .mem_be(s_be), .store_done(s_done), .store_err(s_err));

  store_split_unit #(.XLEN(64), .ALLOW_MISALIGNED(1'b1)) u_d (
    .clk(clk), .rst_n(rst_n), .req_valid(d_valid_i), .req_ready(d_ready),
    .req_addr(d_addr_i), .req_wdata(d_wdata_i), .req_size(d_size),
    .mem_valid(d_valid), .mem_ready(d_ready_i), .mem_addr(d_addr),
    .mem_wdata(d_wdata), .mem_be(d_be), .store_done(d_done), .store_err(d_err));

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue32(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    r_valid = 1'b1; r_addr = addr; r_wdata = data; r_size = size;
    check_eq("accept_ready", 64'(a_ready), 64'd1);
    step();
    r_valid = 1'b0;
  endtask

  task automatic issue64(input logic [63:0] addr, input logic [63:0] data, input logic [1:0] size);
    d_valid_i = 1'b1; d_addr_i = addr; d_wdata_i = data; d_size = size;
    step();
    d_valid_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; m_ready = 1'b1; d_ready_i = 1'b1;
    r_valid = 1'b0; r_addr = '0; r_wdata = '0; r_size = '0;
    d_valid_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_size = '0;
    #12;
    check_eq("rst_valid", 64'(a_valid), 64'd0);
    check_eq("rst_addr", 64'(a_addr), 64'd0);
    check_eq("rst_wdata", 64'(a_wdata), 64'd0);
    check_eq("rst_be", 64'(a_be), 64'd0);
    check_eq("rst_done", 64'(a_done), 64'd0);
    check_eq("rst_err", 64'(a_err), 64'd0);
    check_eq("rst_ready", 64'(a_ready), 64'd1);
    check_eq("rst_d_valid", 64'(d_valid), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    step();

    // SB at 0x1003: single beat in the top lane
    issue32(32'h1003, 32'h0000_00AB, 2'd0);
    check_eq("sb_valid", 64'(a_valid), 64'd1);
    check_eq("sb_addr", 64'(a_addr), 64'h1000);
    check_eq("sb_be", 64'(a_be), 64'h8);
    check_eq("sb_wdata", 64'(a_wdata), 64'hAB00_0000);
    check_eq("sb_done_early", 64'(a_done), 64'd0);
    check_eq("sb_strict_be", 64'(s_be), 64'h8);
    step();
    check_eq("sb_done", 64'(a_done), 64'd1);
    check_eq("sb_idle_valid", 64'(a_valid), 64'd0);
    check_eq("sb_ready", 64'(a_ready), 64'd1);
    check_eq("sb_strict_done", 64'(s_done), 64'd1);
    step();
    check_eq("sb_done_pulse", 64'(a_done), 64'd0);

    // SW at 0x1002: split on u_a, rejected on u_s
    issue32(32'h1002, 32'h1122_3344, 2'd2);
    check_eq("sw_b0_valid", 64'(a_valid), 64'd1);
    check_eq("sw_b0_addr", 64'(a_addr), 64'h1000);
    check_eq("sw_b0_be", 64'(a_be), 64'hC);
    check_eq("sw_b0_wdata", 64'(a_wdata), 64'h3344_0000);
    check_eq("sw_strict_err", 64'(s_err), 64'd1);
    check_eq("sw_strict_valid", 64'(s_valid), 64'd0);
    check_eq("sw_strict_ready", 64'(s_ready), 64'd1);
    step();
    check_eq("sw_b1_addr", 64'(a_addr), 64'h1004);
    check_eq("sw_b1_be", 64'(a_be), 64'h3);
    check_eq("sw_b1_wdata", 64'(a_wdata), 64'h0000_1122);
    check_eq("sw_b1_nodone", 64'(a_done), 64'd0);
    check_eq("sw_strict_err_pulse", 64'(s_err), 64'd0);
    check_eq("sw_strict_valid2", 64'(s_valid), 64'd0);
    step();
    check_eq("sw_done", 64'(a_done), 64'd1);
    check_eq("sw_idle_valid", 64'(a_valid), 64'd0);
    step();
    check_eq("sw_done_once", 64'(a_done), 64'd0);

    // SH at 0x1001: non-crossing single beat on u_a, error on u_s
    issue32(32'h1001, 32'h0000_5566, 2'd1);
    check_eq("sh_strict_err", 64'(s_err), 64'd1);
    check_eq("sh_addr", 64'(a_addr), 64'h1000);
    check_eq("sh_be", 64'(a_be), 64'h6);
    check_eq("sh_wdata", 64'(a_wdata), 64'h0055_6600);
    step();
    check_eq("sh_done", 64'(a_done), 64'd1);
    check_eq("sh_strict_err_pulse", 64'(s_err), 64'd0);
    step();

    // Double-word size on XLEN=32 is illegal
    issue32(32'h2000, 32'h1234_5678, 2'd3);
    check_eq("sd32_err", 64'(a_err), 64'd1);
    check_eq("sd32_valid", 64'(a_valid), 64'd0);
    check_eq("sd32_ready", 64'(a_ready), 64'd1);
    step();
    check_eq("sd32_err_pulse", 64'(a_err), 64'd0);

    // Backpressure: beat must hold while mem_ready is low
    m_ready = 1'b0;
    issue32(32'h2000, 32'hCAFE_F00D, 2'd2);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_valid", 64'(a_valid), 64'd1);
      check_eq("bp_addr", 64'(a_addr), 64'h2000);
      check_eq("bp_wdata", 64'(a_wdata), 64'hCAFE_F00D);
      check_eq("bp_be", 64'(a_be), 64'hF);
      check_eq("bp_nodone", 64'(a_done), 64'd0);
      step();
    end
    check_eq("bp_hold_last", 64'(a_addr), 64'h2000);
    m_ready = 1'b1;
    step();
    check_eq("bp_done", 64'(a_done), 64'd1);
    check_eq("bp_idle", 64'(a_valid), 64'd0);
    step();

    // SH at 0xFFFFFFFF: second beat wraps to address 0
    issue32(32'hFFFF_FFFF, 32'h0000_BEEF, 2'd1);
    check_eq("wr_b0_addr", 64'(a_addr), 64'hFFFF_FFFC);
    check_eq("wr_b0_be", 64'(a_be), 64'h8);
    check_eq("wr_b0_wdata", 64'(a_wdata), 64'hEF00_0000);
    check_eq("wr_strict_err", 64'(s_err), 64'd1);
    step();
    check_eq("wr_b1_valid", 64'(a_valid), 64'd1);
    check_eq("wr_b1_addr", 64'(a_addr), 64'h0);
    check_eq("wr_b1_be", 64'(a_be), 64'h1);
    check_eq("wr_b1_wdata", 64'(a_wdata), 64'h0000_00BE);
    step();
    check_eq("wr_done", 64'(a_done), 64'd1);
    step();

    // Same store, reset asserted during beat1
    issue32(32'hFFFF_FFFF, 32'h0000_BEEF, 2'd1);
    step();
    check_eq("rb_b1_valid", 64'(a_valid), 64'd1);
    check_eq("rb_b1_be", 64'(a_be), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rb_async_valid", 64'(a_valid), 64'd0);
    check_eq("rb_async_be", 64'(a_be), 64'h0);
    @(posedge clk); #1;
    check_eq("rb_nodone", 64'(a_done), 64'd0);
    rst_n = 1'b1;
    check_eq("rb_ready", 64'(a_ready), 64'd1);
    step();
    check_eq("rb_no_beat", 64'(a_valid), 64'd0);
    check_eq("rb_nodone2", 64'(a_done), 64'd0);
    step();
    check_eq("rb_no_beat2", 64'(a_valid), 64'd0);

    // XLEN=64 SD at 0x100C: split across doubleword boundary
    issue64(64'h100C, 64'h1122_3344_5566_7788, 2'd3);
    check_eq("sd_b0_valid", 64'(d_valid), 64'd1);
    check_eq("sd_b0_addr", d_addr, 64'h1008);
    check_eq("sd_b0_be", 64'(d_be), 64'hF0);
    check_eq("sd_b0_wdata", d_wdata, 64'h5566_7788_0000_0000);
    check_eq("sd_err", 64'(d_err), 64'd0);
    step();
    check_eq("sd_b1_addr", d_addr, 64'h1010);
    check_eq("sd_b1_be", 64'(d_be), 64'h0F);
    check_eq("sd_b1_wdata", d_wdata, 64'h0000_0000_1122_3344);
    step();
    check_eq("sd_done", 64'(d_done), 64'd1);
    check_eq("sd_ready", 64'(d_ready), 64'd1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
